// File: rtl/top_level.sv
// Hardwired message encryptor: LFSR-whitens a padded message held in DM1 and writes
// 64 parity-tagged bytes to DM1[64..127].
// Latency: 1 arm edge + 3 load edges + 64 encrypt edges; Ack rises on the 68th edge
// after leaving IDLE.
// Backpressure: none. Start is a level request; once a run begins only Reset stops it.
//
// Ports (top_level): Clk - clock; Reset - async active-low reset;
//                    Start - level request (high arms, low launches); Ack - run complete.

// data_mem: 256x8 data memory, combinational read, one synchronous write port.
// Latency: read 0 cycles, write lands on the next rising edge.
// Backpressure: none; contents are deliberately left untouched by reset.
module data_mem (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_dat_i,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_dat_o
);
  logic [7:0] Core [0:255];

  assign rd_dat_o = Core[rd_addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) Core[wr_addr_i] <= wr_dat_i;
  end
endmodule

// reg_file: 16x8 working registers, each with its own write enable.
// Latency: writes visible the cycle after the enabling edge; reads combinational.
// Backpressure: none; all registers clear on async reset.
module reg_file (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [15:0]      we_i,
  input  logic [15:0][7:0] wd_i,
  output logic [15:0][7:0] rd_o
);
  logic [7:0] Registers [0:15];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 16; r++) Registers[r] <= 8'h00;
    end else begin
      for (int r = 0; r < 16; r++) begin
        if (we_i[r]) Registers[r] <= wd_i[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 16; r++) rd_o[r] = Registers[r];
  end
endmodule

// top_level: sequencer that loads parameters, then encrypts one character per cycle.
// Latency: 68 edges from the launching edge to Ack.
// Backpressure: none; Start changes during a run are ignored.
module top_level (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_PRE  = 3'd1;
  localparam logic [2:0] S_LD_TAP  = 3'd2;
  localparam logic [2:0] S_LD_SEED = 3'd3;
  localparam logic [2:0] S_ENC     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0] state_q, state_d;
  logic       armed_q, armed_d;

  // Reference tap table kept visible for debug; the run uses the pattern from Core[62].
  logic [6:0] taps [0:8];
  assign taps[0] = 7'h60;
  assign taps[1] = 7'h48;
  assign taps[2] = 7'h78;
  assign taps[3] = 7'h72;
  assign taps[4] = 7'h6A;
  assign taps[5] = 7'h69;
  assign taps[6] = 7'h5C;
  assign taps[7] = 7'h7E;
  assign taps[8] = 7'h7B;

  logic             mem_we;
  logic [7:0]       mem_waddr, mem_wdat, mem_raddr, mem_rdat;
  logic [15:0]      rf_we;
  logic [15:0][7:0] rf_wd, rf_rd;

  data_mem DM1 (
    .clk_i     (Clk),
    .we_i      (mem_we),
    .wr_addr_i (mem_waddr),
    .wr_dat_i  (mem_wdat),
    .rd_addr_i (mem_raddr),
    .rd_dat_o  (mem_rdat)
  );

  reg_file RF1 (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .we_i   (rf_we),
    .wd_i   (rf_wd),
    .rd_o   (rf_rd)
  );

  // Encrypt datapath for character index idx.
  logic [7:0] idx, pre_len, msg_ofs, plain, crypt;
  logic [6:0] lfsr, tap_pat, lfsr_nxt, crypt_lo, seed_fix;
  logic       in_msg;

  assign idx      = rf_rd[3];
  assign pre_len  = rf_rd[0];
  assign tap_pat  = rf_rd[1][6:0];
  assign lfsr     = rf_rd[2][6:0];
  // msg_ofs wraps while idx < pre_len; the explicit compare keeps those slots at zero.
  assign msg_ofs  = idx - pre_len;
  assign in_msg   = (idx >= pre_len) && (msg_ofs <= 8'd60);
  assign plain    = in_msg ? (mem_rdat - 8'h20) : 8'h00;
  assign crypt_lo = plain[6:0] ^ lfsr;
  assign crypt    = {^crypt_lo, crypt_lo};
  assign lfsr_nxt = {lfsr[5:0], ^(lfsr & tap_pat)};
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  assign seed_fix = (mem_rdat[6:0] == 7'd0) ? 7'd1 : mem_rdat[6:0];

  assign mem_waddr = 8'd64 + idx;
  assign mem_wdat  = crypt;

  always_comb begin
    case (state_q)
      S_LD_PRE:  mem_raddr = 8'd61;
      S_LD_TAP:  mem_raddr = 8'd62;
      S_LD_SEED: mem_raddr = 8'd63;
      default:   mem_raddr = msg_ofs;
    endcase
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    mem_we  = 1'b0;
    rf_we   = '0;
    rf_wd   = '0;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !Start) begin
          state_d = S_LD_PRE;
          armed_d = 1'b0;
        end else if (Start) begin
          armed_d = 1'b1;
        end
      end
      S_LD_PRE: begin
        rf_we[0] = 1'b1;
        rf_wd[0] = mem_rdat;
        state_d  = S_LD_TAP;
      end
      S_LD_TAP: begin
        rf_we[1] = 1'b1;
        rf_wd[1] = {1'b0, mem_rdat[6:0]};
        state_d  = S_LD_SEED;
      end
      S_LD_SEED: begin
        rf_we[2] = 1'b1;
        rf_wd[2] = {1'b0, seed_fix};
        rf_we[3] = 1'b1;
        rf_wd[3] = 8'h00;
        state_d  = S_ENC;
      end
      S_ENC: begin
        mem_we   = 1'b1;
        rf_we[2] = 1'b1;
        rf_wd[2] = {1'b0, lfsr_nxt};
        rf_we[3] = 1'b1;
        rf_wd[3] = idx + 8'd1;
        rf_we[4] = 1'b1;
        rf_wd[4] = plain;
        rf_we[5] = 1'b1;
        rf_wd[5] = crypt;
        if (idx == 8'd63) state_d = S_DONE;
      end
      S_DONE: begin
        armed_d = 1'b0;
        if (Start) begin
          state_d = S_IDLE;
          armed_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        armed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  assign Ack = (state_q == S_DONE);

  // Sink for bits that exist only for visibility.
  logic unused_bits;
  assign unused_bits = ^{rf_rd, taps[0], taps[1], taps[2], taps[3], taps[4],
                         taps[5], taps[6], taps[7], taps[8]};
endmodule

// File: tb/tb_top_level.sv
// Testbench for top_level: table-driven runs checked against hand values and a
// software model, plus hand-written reset and handshake sequences.
// Uses backdoor access to DM1.Core and RF1.Registers.
module tb_top_level;
  logic Clk, Reset, Start, Ack;

  top_level dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       msg;   // 0: Watson text, 1: 52-char boundary text
    logic [7:0] pre, tap, seed;
    logic [7:0] a0, e0, a1, e1;
  } vec_t;
  vec_t vecs [4];

  string msg0 = "Mr. Watson, come here. I want to see you.";
  logic [7:0] sh      [0:63];
  logic [7:0] exp_out [0:63];
  logic [7:0] ref_out [0:63];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_cfg(input logic msg, input logic [7:0] pre, tap, seed);
    for (int j = 0; j <= 60; j++) begin
      if (!msg) sh[j] = (j < msg0.len()) ? msg0[j] : 8'h20;
      else      sh[j] = (j < 52) ? 8'(32 + ((j * 7 + 3) % 128)) : 8'h20;
    end
    sh[61] = pre;
    sh[62] = tap;
    sh[63] = seed;
    for (int j = 0; j < 64; j++)   dut.DM1.Core[j] = sh[j];
    for (int j = 64; j < 128; j++) dut.DM1.Core[j] = 8'hEE;
  endtask

  // Independent software model of the expected 64 output bytes.
  task automatic model();
    int s, p, x, fb, pre, tap;
    pre = int'(sh[61]);
    tap = int'(sh[62]) & 'h7F;
    s   = int'(sh[63]) & 'h7F;
    if (s == 0) s = 1;
    for (int i = 0; i < 64; i++) begin
      if (i >= pre && (i - pre) <= 60) p = (int'(sh[i - pre]) - 32) & 255;
      else p = 0;
      x = (p ^ s) & 'h7F;
      exp_out[i] = 8'(x | (($countones(x) & 1) << 7));
      fb = $countones(s & tap) & 1;
      s  = ((s << 1) & 'h7E) | fb;
    end
  endtask

  // Arm, launch, measure Ack latency, then release with Start=1.
  task automatic do_run();
    int lat;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge Clk); #1;
      if (Ack) begin lat = c; break; end
      if (c == 30) Start = 1'b1;   // mid-run toggle must be ignored
      if (c == 31) Start = 1'b0;
    end
    check("ack_latency", lat, 68);
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1;
    check("ack_drop", int'(Ack), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nz;
    vecs[0] = '{msg:1'b0, pre:8'd13, tap:8'h7B, seed:8'h01, a0:8'd64, e0:8'h81, a1:8'd66, e1:8'h06};
    vecs[1] = '{msg:1'b0, pre:8'd13, tap:8'h60, seed:8'h01, a0:8'd64, e0:8'h81, a1:8'd65, e1:8'h82};
    vecs[2] = '{msg:1'b0, pre:8'd13, tap:8'h7B, seed:8'h00, a0:8'd64, e0:8'h81, a1:8'd65, e1:8'h03};
    vecs[3] = '{msg:1'b1, pre:8'd15, tap:8'h7B, seed:8'h01, a0:8'd64, e0:8'h81, a1:8'd65, e1:8'h03};

    Reset = 1'b0;
    Start = 1'b0;
    #12;
    check("reset_ack", int'(Ack), 0);
    nz = 0;
    for (int r = 0; r < 16; r++) if (dut.RF1.Registers[r] != 8'h00) nz++;
    check("reset_regs_nonzero", nz, 0);

    // Start already low at reset release: must not run.
    @(negedge Clk); Reset = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check("no_run_without_arm_R0", int'(dut.RF1.Registers[0]), 0);
    check("no_run_without_arm_ack", int'(Ack), 0);

    for (int v = 0; v < 4; v++) begin
      @(negedge Clk);
      load_cfg(vecs[v].msg, vecs[v].pre, vecs[v].tap, vecs[v].seed);
      model();
      if (v == 0) for (int j = 0; j < 64; j++) ref_out[j] = exp_out[j];
      do_run();
      check($sformatf("v%0d_hand_a0", v), int'(dut.DM1.Core[int'(vecs[v].a0)]), int'(vecs[v].e0));
      check($sformatf("v%0d_hand_a1", v), int'(dut.DM1.Core[int'(vecs[v].a1)]), int'(vecs[v].e1));
      for (int j = 0; j < 64; j++) begin
        if (vecs[v].seed == 8'h00)
          check($sformatf("v%0d_vs_seed1_byte%0d", v, 64 + j), int'(dut.DM1.Core[64 + j]), int'(ref_out[j]));
        else
          check($sformatf("v%0d_model_byte%0d", v, 64 + j), int'(dut.DM1.Core[64 + j]), int'(exp_out[j]));
      end
      if (v == 3) begin
        check("bnd_R4_last_plain", int'(dut.RF1.Registers[4]), 'h53);
        check("bnd_R3_index", int'(dut.RF1.Registers[3]), 64);
        check("bnd_R0_pre", int'(dut.RF1.Registers[0]), 15);
      end
    end

    // Reset in the middle of the encrypt phase.
    @(negedge Clk);
    load_cfg(1'b0, 8'd13, 8'h7B, 8'h01);
    model();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (25) @(posedge Clk);   // last of these writes index 20
    @(negedge Clk); Reset = 1'b0;
    #1;
    check("mid_reset_ack", int'(Ack), 0);
    nz = 0;
    for (int r = 0; r < 16; r++) if (dut.RF1.Registers[r] != 8'h00) nz++;
    check("mid_reset_regs_nonzero", nz, 0);
    for (int j = 0; j <= 20; j++)
      check($sformatf("mid_reset_kept%0d", 64 + j), int'(dut.DM1.Core[64 + j]), int'(exp_out[j]));
    check("mid_reset_unwritten85", int'(dut.DM1.Core[85]), 'hEE);
    for (int j = 0; j < 64; j++)
      check($sformatf("mid_reset_input%0d", j), int'(dut.DM1.Core[j]), int'(sh[j]));
    @(negedge Clk); Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("post_reset_idle_R0", int'(dut.RF1.Registers[0]), 0);
    do_run();
    for (int j = 0; j < 64; j++)
      check($sformatf("rerun_byte%0d", 64 + j), int'(dut.DM1.Core[64 + j]), int'(exp_out[j]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/top_level.md
# top_level

Hardwired message-encryption engine for the CSE141L Program 1 flow. It owns the data memory `DM1`, working register file `RF1` and LFSR tap table `taps`. Software/bench preloads a padded ASCII message and LFSR parameters into `DM1`, releases `Start`, and the block writes 64 encrypted, parity-tagged bytes to `DM1[64..127]`. It then raises `Ack`.

## Interface
- No parameters (memory depth 256×8, register file 16×8 and tap table 9×7 are fixed).
- `Clk`  in  1  Sole clock; all state changes on the rising edge.
- `Reset`  in  1  Reset, asynchronous and active-low (low = reset).
- `Start`  in  1  Level request. While high, the block holds idle and arms; a run begins once it is low.
- `Ack`  out  1  Done flag. High when the run has completed.
- Hierarchy names are fixed for backdoor access:
  - `DM1.Core[0:255]` (8-bit)
  - `RF1.Registers[0:15]` (8-bit)
  - `taps[0:8]` (7-bit constants: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B)

## Operation
- **Memory map**
  - `Core[0..60]`: message, ASCII 0x20..0x9F, space-padded.
  - `Core[61]`: pre_length (10..15).
  - `Core[62]`: tap pattern in bits[6:0].
  - `Core[63]`: LFSR init in bits[6:0].
  - `Core[64..127]`: output.
  - `Core[128..255]`: unused scratch.
- `DM1`: combinational read, synchronous write, one write port. Contents are **not** affected by `Reset`.
- **Register usage** (all cleared to 0 on reset; bits above the field width are written as 0):
  - `R0` = pre_length
  - `R1` = tap pattern
  - `R2` = LFSR state (7b)
  - `R3` = index i
  - `R4` = plain char
  - `R5` = last crypt byte
  - `R6..R15` = 0
- **FSM states:** IDLE, LD_PRE, LD_TAP, LD_SEED, ENC, DONE.
- **IDLE**
  - `armed` is set when `Start`=1.
  - If `armed` and `Start`=0, go to LD_PRE.
- **LD_PRE:** `R0` ← `Core[61]`.
- **LD_TAP:** `R1` ← `Core[62]`&0x7F.
- **LD_SEED:**
  - `R2` ← `Core[63]`&0x7F.
  - If that value is 0, substitute 0x01.
  - `R3` ← 0.
- **ENC** (one character per cycle, i = `R3`):
  - k = i − `R0`.
  - Plain p = (i ≥ `R0` and k ≤ 60) ? `Core[k]` − 0x20 (mod 256) : 0x00.
  - c = (p ^ {0,`R2`}); c[7] = ^c[6:0] (even parity over the low 7 bits).
  - Write `Core[64+i]` ← c. Also `R4` ← p, `R5` ← c.
  - LFSR update: `R2` ← {`R2`[5:0], ^(`R2` & `R1`[6:0])}.
  - `R3` ← i+1. If i = 63, go to DONE.
- **DONE:**
  - `Ack`=1; `armed` cleared.
  - Stays in DONE while `Start`=0.
  - `Start`=1 returns to IDLE (armed), `Ack`→0.
- `taps` is a constant lookup table for debug/visibility only. The pattern actually used is `Core[62]`, unvalidated; any value works.
- **Reset mid-run:** FSM → IDLE, `Ack`=0, registers 0, `armed`=0. Already-written output bytes remain in `DM1`.

## Timing
- **Reset values:** `Ack`=0, state IDLE, `armed`=0, all `RF1` = 0.
- **Latency:** first rising edge with `Start`=0 while armed enters LD_PRE. Then 3 load cycles and 64 ENC cycles; DONE (`Ack`=1) is reached on the 68th edge after leaving IDLE.
- `Core[64+i]` is valid after the ENC edge for index i. All 64 outputs are valid when `Ack` rises.
- `Start` toggling during LD_*/ENC is ignored. Only `Reset` aborts a run.
- If `Start` is already 0 at reset release, the block waits for a 1→0 sequence before running.

## Test plan
- **Default run**
  - Setup: "Mr. Watson, come here. I want to see you." in `Core[0..]`, 0x20 elsewhere in 0..60; `Core[61]`=13, `Core[62]`=0x7B, `Core[63]`=0x01. Start=1, then 0.
  - Required: `Core[64]`=0x81, `Core[65]`=0x03, `Core[66]`=0x06.
  - Required: all 64 bytes match a software model.
- **Tap 0x60, init 0x01**
  - Required: `Core[64]`=0x81, `Core[65]`=0x82.
- **Handshake**
  - Required: `Ack` stays 0 through the run and is 1 exactly 68 cycles after Start falls.
  - Required: `Ack` is 0 one cycle after Start returns to 1.
- **Zero seed**
  - Stimulus: `Core[63]`=0x00.
  - Required: output identical to the seed-0x01 run.
- **Reset mid-run**
  - Stimulus: drive Reset low at ENC i=20.
  - Required: `Ack`=0 and registers 0 immediately; `Core[64..84]` retained; `Core[0..63]` untouched.
  - Required: after rerun, full correct output.
- **Boundary**
  - Stimulus: 52-char message with pre_length 15.
  - Required: `Core[127]` encrypts `Core[48]`−0x20; pre-pad slots encrypt 0x00.
